fpu_mult_iter: RTL and testbench



---
 rtl/fpu_mult_iter_pkg.sv | 19 +
 rtl/fpu_round_norm.sv | 68 ++++++
 rtl/fpu_mult_iter.sv | 134 +++++++++++++
 tb/tb_fpu_mult_iter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fpu_mult_iter_pkg.sv
// Shared FPU definitions: single-precision defaults, multiplier sequencer states, rounding modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_mult_iter_pkg;

  localparam int FPU_E    = 8;
  localparam int FPU_F    = 23;
  localparam int FPU_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } mul_state_t;

  // Only round-to-nearest-even exists today; other encodings are reserved.
  localparam logic [1:0] RND_RNE = 2'b00;

endpackage

// File: rtl/fpu_round_norm.sv
// Normalise, round-to-nearest-even and classify a raw significand product.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs when it wants them.
module fpu_round_norm
  import fpu_mult_iter_pkg::*;
#(
  parameter int E = FPU_E,
  parameter int F = FPU_F
) (
  input  logic [2*F+1:0]      prod_i,
  input  logic signed [E+1:0] exp_raw_i,
  input  logic                zero_i,
  output logic [E-1:0]        exp_o,
  output logic [F:0]          frac_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                zero_o
);

  localparam logic [1:0]          RND_MODE = RND_RNE;
  localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);

  logic               hi;
  logic [F:0]         mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [F+1:0]       mant_rnd;
  logic               carry;
  logic [F:0]         frac_rnd;
  logic signed [E+1:0] exp_fin;

  // Normalise to [1,2), round, fold the carries into the exponent, then apply special cases by priority.
  always_comb begin
    hi       = prod_i[2*F+1];
    mant     = hi ? prod_i[2*F+1:F+1] : prod_i[2*F:F];
    guard    = hi ? prod_i[F] : prod_i[F-1];
    sticky   = hi ? (|prod_i[F-1:0]) : (|prod_i[F-2:0]);
    round_up = (RND_MODE == RND_RNE) ? (guard & (sticky | mant[0])) : 1'b0;
    mant_rnd = {1'b0, mant} + {{(F+1){1'b0}}, round_up};
    carry    = mant_rnd[F+1];
    // A carry-out only happens from all-ones, so the shifted value is exactly 1.0.
    frac_rnd = carry ? mant_rnd[F+1:1] : mant_rnd[F:0];
    exp_fin  = $signed(exp_raw_i + {{(E+1){1'b0}}, hi} + {{(E+1){1'b0}}, carry});

    exp_o       = exp_fin[E-1:0];
    frac_o      = frac_rnd;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    zero_o      = 1'b0;

    if (zero_i) begin
      exp_o  = '0;
      frac_o = '0;
      zero_o = 1'b1;
    end else if (exp_fin >= EXP_MAX) begin
      exp_o      = '1;
      frac_o     = '0;
      overflow_o = 1'b1;
    end else if (exp_fin[E+1] || (exp_fin == '0)) begin
      exp_o       = '0;
      frac_o      = '0;
      underflow_o = 1'b1;
      zero_o      = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_mult_iter.sv
// Iterative FP multiplier retiring RADIX_BITS multiplier bits per cycle, then normalise/round.
// Latency: done rises (F+1)/RADIX_BITS + 1 clocks after the start-accepting edge, for every operand.
// Backpressure: start is ignored while busy; results hold until the next done.
module fpu_mult_iter
  import fpu_mult_iter_pkg::*;
#(
  parameter int E          = FPU_E,
  parameter int F          = FPU_F,
  parameter int RADIX_BITS = 1,
  parameter int BIAS       = FPU_BIAS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_sign,
  input  logic [E-1:0] a_exponent,
  input  logic [F:0]   a_fraction,
  input  logic         b_sign,
  input  logic [E-1:0] b_exponent,
  input  logic [F:0]   b_fraction,
  output logic         busy,
  output logic         done,
  output logic         result_s,
  output logic [E-1:0] result_e,
  output logic [F:0]   result_f,
  output logic         overflow,
  output logic         underflow,
  output logic         result_zero
);

  localparam int W  = F + 1;
  localparam int R  = RADIX_BITS;
  localparam int N  = W / R;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [E+1:0]  BIAS_X = (E+2)'(BIAS);

  if ((W % R) != 0) begin : g_bad_radix
    $error("RADIX_BITS must divide F+1");
  end
  if (BIAS != ((1 << (E - 1)) - 1)) begin : g_bad_bias
    $error("BIAS must equal 2**(E-1)-1");
  end

  mul_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic [2*W-1:0]      prod_q, prod_d;
  logic [W-1:0]        mcand_q;
  logic signed [E+1:0] exp_raw_q, exp_raw_d;
  logic                zero_in_q;
  logic                sign_q;

  logic [R-1:0]        mplr_bits;
  logic [W+R-1:0]      acc;
  logic [2*W+R-1:0]    ext;

  logic [E-1:0]        rn_exp;
  logic [F:0]          rn_frac;
  logic                rn_ovf, rn_unf, rn_zero;

  // One radix step: add multiplicand x low multiplier digit to the upper half, then shift right.
  always_comb begin
    mplr_bits = prod_q[R-1:0];
    acc       = {{R{1'b0}}, prod_q[2*W-1:W]} + ({{R{1'b0}}, mcand_q} * {{W{1'b0}}, mplr_bits});
    ext       = {acc, prod_q[W-1:0]};
    prod_d    = ext[2*W+R-1:R];
    exp_raw_d = $signed({2'b00, a_exponent} + {2'b00, b_exponent} - BIAS_X);
  end

  fpu_round_norm #(.E(E), .F(F)) u_round_norm (
    .prod_i      (prod_q),
    .exp_raw_i   (exp_raw_q),
    .zero_i      (zero_in_q),
    .exp_o       (rn_exp),
    .frac_o      (rn_frac),
    .overflow_o  (rn_ovf),
    .underflow_o (rn_unf),
    .zero_o      (rn_zero)
  );

  // Sequencer plus operand/accumulator registers and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      exp_raw_q   <= '0;
      zero_in_q   <= 1'b0;
      sign_q      <= 1'b0;
      done        <= 1'b0;
      result_s    <= 1'b0;
      result_e    <= '0;
      result_f    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      result_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q    <= a_sign ^ b_sign;
            exp_raw_q <= exp_raw_d;
            zero_in_q <= (a_exponent == '0) || (b_exponent == '0);
            mcand_q   <= a_fraction;
            prod_q    <= {{W{1'b0}}, b_fraction};
            cnt_q     <= '0;
            state_q   <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= NORM;
        end
        NORM: begin
          done        <= 1'b1;
          result_s    <= sign_q;
          result_e    <= rn_exp;
          result_f    <= rn_frac;
          overflow    <= rn_ovf;
          underflow   <= rn_unf;
          result_zero <= rn_zero;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_mult_iter.sv
// Directed bench: a radix-1 and a radix-4 instance share stimulus and are checked against hand-computed results.
// Latency: expects done 25 (radix 1) and 7 (radix 4) clocks after the start edge.
// Backpressure: also exercises start-while-busy and asynchronous abort.
module tb_fpu_mult_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [7:0]  a_exponent = '0, b_exponent = '0;
  logic [23:0] a_fraction = '0, b_fraction = '0;

  logic        busy1, done1, s1, ov1, un1, z1;
  logic [7:0]  e1;
  logic [23:0] f1;
  logic        busy4, done4, s4, ov4, un4, z4;
  logic [7:0]  e4;
  logic [23:0] f4;

  wire [35:0] res1 = {s1, e1, f1, ov1, un1, z1};
  wire [35:0] res4 = {s4, e4, f4, ov4, un4, z4};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_mult_iter #(.RADIX_BITS(1)) u_r1 (
    .clk(clk), .rst(rst), .start(start),
    .a_sign(a_sign), .a_exponent(a_exponent), .a_fraction(a_fraction),
    .b_sign(b_sign), .b_exponent(b_exponent), .b_fraction(b_fraction),
    .busy(busy1), .done(done1), .result_s(s1), .result_e(e1), .result_f(f1),
    .overflow(ov1), .underflow(un1), .result_zero(z1)
  );

  fpu_mult_iter #(.RADIX_BITS(4)) u_r4 (
    .clk(clk), .rst(rst), .start(start),
    .a_sign(a_sign), .a_exponent(a_exponent), .a_fraction(a_fraction),
    .b_sign(b_sign), .b_exponent(b_exponent), .b_fraction(b_fraction),
    .busy(busy4), .done(done4), .result_s(s4), .result_e(e4), .result_f(f4),
    .overflow(ov4), .underflow(un4), .result_zero(z4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, watch both instances for 40 clocks, check latency, done count and results.
  // glitch>0 re-pulses start (with overflow operands) right after clock 'glitch' while busy.
  task automatic run_op(input string tag,
                        input logic sa, input logic [7:0] ea, input logic [23:0] fa,
                        input logic sb, input logic [7:0] eb, input logic [23:0] fb,
                        input logic xs, input logic [7:0] xe, input logic [23:0] xf,
                        input logic xov, input logic xun, input logic xz,
                        input int glitch);
    int lat1, lat4, nd1, nd4;
    logic [35:0] cap1, cap4, exp_res;
    lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0; cap1 = '0; cap4 = '0;
    exp_res = {xs, xe, xf, xov, xun, xz};
    @(negedge clk);
    a_sign = sa; a_exponent = ea; a_fraction = fa;
    b_sign = sb; b_exponent = eb; b_fraction = fb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (glitch > 0 && cyc == glitch) begin
        start = 1'b1;
        a_exponent = 8'd254; a_fraction = 24'hFFFFFF;
        b_exponent = 8'd254; b_fraction = 24'hFFFFFF;
      end
      if (glitch > 0 && cyc == glitch + 1) start = 1'b0;
      if (cyc == 1) begin
        check({tag, "/busy1"}, 64'(busy1), 64'd1);
        check({tag, "/busy4"}, 64'(busy4), 64'd1);
      end
      if (done1) begin
        nd1++;
        if (nd1 == 1) begin lat1 = cyc; cap1 = res1; end
      end
      if (done4) begin
        nd4++;
        if (nd4 == 1) begin lat4 = cyc; cap4 = res4; end
      end
    end
    check({tag, "/lat1"}, 64'(lat1), 64'd25);
    check({tag, "/lat4"}, 64'(lat4), 64'd7);
    check({tag, "/ndone1"}, 64'(nd1), 64'd1);
    check({tag, "/ndone4"}, 64'(nd4), 64'd1);
    check({tag, "/res1"}, 64'(cap1), 64'(exp_res));
    check({tag, "/res4"}, 64'(cap4), 64'(exp_res));
    check({tag, "/hold4"}, 64'(res4), 64'(exp_res));
    check({tag, "/idle"}, 64'({busy1, busy4}), 64'd0);
  endtask

  initial begin
    int nd;
    #2;
    check("reset_r1", 64'({busy1, done1, res1}), 64'd0);
    check("reset_r4", 64'({busy4, done4, res4}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //          tag           sa  ea      fa            sb  eb      fb            xs  xe      xf            ov  un  z   glitch
    run_op("1.5x2",   1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000, 1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 1'b0, 0);
    run_op("tie_even",1'b0, 8'd127, 24'h800001, 1'b1, 8'd127, 24'hC00000, 1'b1, 8'd127, 24'hC00002, 1'b0, 1'b0, 1'b0, 0);
    run_op("ovf",     1'b0, 8'd254, 24'hFFFFFF, 1'b0, 8'd254, 24'hFFFFFF, 1'b0, 8'hFF,  24'h000000, 1'b1, 1'b0, 1'b0, 0);
    run_op("unf",     1'b0, 8'd1,   24'h800000, 1'b0, 8'd1,   24'h800000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b1, 1'b1, 0);
    run_op("zero_a",  1'b1, 8'd0,   24'h123456, 1'b0, 8'd130, 24'hA00000, 1'b1, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b1, 0);
    run_op("rnd_carry",1'b0,8'd127, 24'hFFFFFE, 1'b0, 8'd127, 24'h800001, 1'b0, 8'd128, 24'h800000, 1'b0, 1'b0, 1'b0, 0);
    run_op("emax",    1'b1, 8'd254, 24'h800000, 1'b1, 8'd127, 24'h800000, 1'b0, 8'd254, 24'h800000, 1'b0, 1'b0, 1'b0, 0);
    run_op("ovf_edge",1'b0, 8'd254, 24'h800000, 1'b0, 8'd128, 24'h800000, 1'b0, 8'hFF,  24'h000000, 1'b1, 1'b0, 1'b0, 0);
    run_op("emin",    1'b0, 8'd1,   24'h800000, 1'b1, 8'd127, 24'h800000, 1'b1, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 0);
    run_op("unf_edge",1'b0, 8'd63,  24'h800000, 1'b0, 8'd64,  24'h800000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b1, 1'b1, 0);
    run_op("zero_b",  1'b0, 8'd5,   24'h800000, 1'b1, 8'd0,   24'h000000, 1'b1, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b1, 0);
    run_op("busy_start",1'b0,8'd127,24'hC00000, 1'b0, 8'd128, 24'h800000, 1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 1'b0, 3);

    // Asynchronous abort mid-operation.
    @(negedge clk);
    a_sign = 1'b0; a_exponent = 8'd127; a_fraction = 24'hC00000;
    b_sign = 1'b0; b_exponent = 8'd128; b_fraction = 24'h800000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort/busy_before", 64'({busy1, busy4}), 64'b11);
    #2 rst = 1'b1;
    #1;
    check("abort/r1_cleared", 64'({busy1, done1, res1}), 64'd0);
    check("abort/r4_cleared", 64'({busy4, done4, res4}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done1 || done4) nd++;
    end
    check("abort/no_done", 64'(nd), 64'd0);

    run_op("after_rst",1'b0,8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000, 1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
